int_ctrl: RTL

- Interrupt controller placed directly upstream of the control unit.
- Synchronises and edge-detects the external interrupt lines and holds the request (solicitud) and attention (atencion) registers.
- Drives them to the control unit as data_s and int_a, and consumes the unit's one-hot s_calli/s_reti strobes to move requests into and out of service.
- Also provides the vector address of the winning interrupt to the PC mux.

---
 rtl/int_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises external lines, tracks pending and in-service
// interrupts, and selects the winning vector address for the PC mux.
module int_ctrl #(
   parameter int               N_INT      = 8,
   parameter int               PC_W       = 10,
   parameter logic [PC_W-1:0]  VEC_BASE   = 10'd1008,
   parameter int               VEC_STRIDE = 2,
   parameter logic [N_INT-1:0] MASK_RST   = 8'hFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_INT-1:0] ext_int,
   input  logic [N_INT-1:0] s_calli,
   input  logic [N_INT-1:0] s_reti,
   input  logic             we_mask,
   input  logic [N_INT-1:0] mask_in,
   output logic [N_INT-1:0] data_s,
   output logic [N_INT-1:0] int_a,
   output logic             vec_valid,
   output logic [PC_W-1:0]  vec_addr
);

   localparam int IDX_W = (N_INT > 1) ? $clog2(N_INT) : 1;

   logic [N_INT-1:0] sync1;
   logic [N_INT-1:0] sync2;
   logic [N_INT-1:0] last;
   logic [N_INT-1:0] req;
   logic [N_INT-1:0] att;
   logic [N_INT-1:0] mask;
   logic [N_INT-1:0] rise;
   logic [IDX_W-1:0] hp_s;
   logic [IDX_W-1:0] hp_a;
   logic [PC_W-1:0]  vec_off;

   assign rise = sync2 & ~last;

   // A fresh edge beats a simultaneous call on the same line, and a call beats a
   // simultaneous return, so neither a new request nor a nested entry is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         last  <= '0;
         req   <= '0;
         att   <= '0;
         mask  <= MASK_RST;
      end else begin
         sync1 <= ext_int;
         sync2 <= sync1;
         last  <= sync2;
         req   <= (req & ~s_calli) | rise;
         att   <= (att & ~s_reti) | s_calli;
         if (we_mask) begin
            mask <= mask_in;
         end
      end
   end

   assign data_s = req & mask;
   assign int_a  = att;

   always_comb begin
      hp_s = '0;
      hp_a = '0;
      for (int i = 0; i < N_INT; i++) begin
         if (data_s[i]) hp_s = IDX_W'(i);
         if (att[i])    hp_a = IDX_W'(i);
      end
   end

   assign vec_valid = (data_s != '0) && ((att == '0) || (hp_s > hp_a));
   assign vec_off   = PC_W'(hp_s) * PC_W'(VEC_STRIDE);
   assign vec_addr  = vec_valid ? (VEC_BASE + vec_off) : VEC_BASE;

endmodule
